cpu_mul_wb_scheduler: RTL
=========================

Name: cpu_mul_wb_scheduler

Overview:
- Scheduler for the pipelined multiplier and the shared register-file write port.
- Keeps a shadow scoreboard of in-flight multiply destinations and raises an issue stall on RAW/WAW hazards against them.
- Arbitrates the single bank-register write port between the normal writeback stage and completing multiplies, parking displaced multiply results in a small FIFO.
- Sits between decode/issue, the execute-stage multiplier and the bank register file.

Parameters:
NUM_REGS, 32, architectural register count; register ids are $clog2(NUM_REGS) bits (RW below).
REG_WIDTH, 32, data width.
MUL_STAGES, 5, multiplier latency in cycles from issue to mul_done.
BUF_DEPTH, 2, multiply-result holdover FIFO entries (power of two, >=2).

Ports:
clock  in  1  clock.
reset  in  1  reset, synchronous, active-high.
issue_valid  in  1  instruction presented by the issue stage.
issue_is_mul  in  1  instruction is ALU_MUL_OP.
issue_wr  in  1  instruction writes issue_rd.
issue_rd  in  RW  destination id.
issue_ra_use / issue_rb_use  in  1 each  source operand read.
issue_ra / issue_rb  in  RW each  source ids.
issue_stall  out  1  hold the issue stage this cycle.
mul_done_valid  in  1  multiplier final-stage result valid.
mul_done_rd  in  RW  result destination.
mul_done_data  in  REG_WIDTH  result value.
wb_valid  in  1  normal writeback request.
wb_rd  in  RW  normal writeback destination.
wb_data  in  REG_WIDTH  normal writeback value.
wb_ready  out  1  normal writeback accepted this cycle.
rf_we  out  1  register-file write enable.
rf_waddr  out  RW  write address.
rf_wdata  out  REG_WIDTH  write data.
buf_count  out  $clog2(BUF_DEPTH)+1  FIFO occupancy, for debug and coverage.

Behaviour:
- Accept: issue fires when issue_valid && !issue_stall.
- Scoreboard: MUL_STAGES-entry shift register of {valid, rd}, advancing every cycle.
  - Stage 0 loads {fire && issue_is_mul && issue_wr, issue_rd}.
  - The last stage must match mul_done_valid/mul_done_rd; a mismatch is a bench assertion failure.
- Pending set = scoreboard valid entries plus FIFO entries.
- issue_stall (combinational) = issue_valid && any of:
  - issue_ra_use and issue_ra is pending;
  - issue_rb_use and issue_rb is pending;
  - issue_wr and issue_rd is pending (WAW, applies to both mul and non-mul).
  - Register 0 never matches.
- An entry stops being pending only in the cycle after its RF write.
- Write-port priority, evaluated each cycle (combinational outputs):
  1. FIFO full (count==BUF_DEPTH): FIFO head writes, wb_ready=0.
  2. Else if wb_valid: normal writeback writes, wb_ready=1.
  3. Else if FIFO non-empty: FIFO head writes.
  4. Else if mul_done_valid: direct mul write.
  - wb_ready=1 whenever the FIFO is not full.
- mul_done_valid is pushed to the FIFO unless it takes the direct path (case 4).
  - Simultaneous pop and push keeps the count unchanged, so no overflow is possible.
  - The upstream writeback stage must hold wb_* stable while wb_ready=0.
- Writes with rd==0 drive rf_we=0 but still consume the arbitration slot and free the entry.
- FIFO pointers wrap modulo BUF_DEPTH; strict FIFO order is preserved.
- Reset (including mid-operation): scoreboard and FIFO cleared, count=0, all in-flight results discarded. Post-reset outputs: issue_stall=0, wb_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, buf_count=0.
- Outputs in the reset cycle must already hold these values.

Test Plan:
- Mul r3 issued at cycle 0, no wb traffic -> rf_we=1 with waddr=3 and the mul data at cycle 5; issue of add r4=r3+r1 stalls cycles 1-5 and fires at cycle 6.
- Mul r5 completes while wb_valid (r7=0x11) -> cycle N: rf writes r7, buf_count=1; cycle N+1 (wb idle): rf writes r5, buf_count 1->0.
- Three back-to-back muls (r1,r2,r6) complete under continuous wb_valid -> buf_count reaches 2; next cycle the FIFO head r1 writes with wb_ready=0; order r1,r2,r6 preserved, no data lost.
- Non-mul writing r9 while mul r9 in flight -> stalled until the cycle after the mul r9 RF write; sources/dest r0 never stall.
- Reset asserted with 2 muls in flight and buf_count=1 -> next cycle buf_count=0, issue_stall=0; late mul_done with the valid bit deasserted produces no rf_we.
- Simultaneous mul_done and FIFO-full drain for 4 cycles -> buf_count constant at 2, one RF write per cycle, wb_ready held low throughout.

Source files
------------

// File: rtl/cpu_mul_wb_scheduler.sv
// cpu_mul_wb_scheduler
//   Schedules the pipelined multiplier against the single register-file write
//   port. A shadow scoreboard tracks in-flight multiply destinations. A small
//   holdover FIFO parks multiply results that lose the write port to the
//   normal writeback stage. Issue is stalled on RAW/WAW hazards against
//   either one.
//
// Ports
//   clock, reset          : clock; synchronous active-high reset
//   issue_*               : instruction presented by the issue stage
//   issue_stall           : hold the issue stage this cycle (combinational)
//   mul_done_*            : multiplier final-stage result
//   wb_valid/rd/data      : normal writeback request
//   wb_ready              : normal writeback accepted this cycle
//   rf_we/waddr/wdata     : register-file write port
//   buf_count             : holdover FIFO occupancy (debug/coverage)
//
// Handshake: a writeback transfers in any cycle where wb_valid && wb_ready.
// While wb_ready is low the writeback stage holds wb_* stable. Issue fires
// when issue_valid && !issue_stall.
module cpu_mul_wb_scheduler #(
    parameter int NUM_REGS   = 32,
    parameter int REG_WIDTH  = 32,
    parameter int MUL_STAGES = 5,
    parameter int BUF_DEPTH  = 2,
    localparam int RW = $clog2(NUM_REGS),
    localparam int CW = $clog2(BUF_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_is_mul,
    input  logic                 issue_wr,
    input  logic [RW-1:0]        issue_rd,
    input  logic                 issue_ra_use,
    input  logic                 issue_rb_use,
    input  logic [RW-1:0]        issue_ra,
    input  logic [RW-1:0]        issue_rb,
    output logic                 issue_stall,
    input  logic                 mul_done_valid,
    input  logic [RW-1:0]        mul_done_rd,
    input  logic [REG_WIDTH-1:0] mul_done_data,
    input  logic                 wb_valid,
    input  logic [RW-1:0]        wb_rd,
    input  logic [REG_WIDTH-1:0] wb_data,
    output logic                 wb_ready,
    output logic                 rf_we,
    output logic [RW-1:0]        rf_waddr,
    output logic [REG_WIDTH-1:0] rf_wdata,
    output logic [CW-1:0]        buf_count
);

    localparam int PW = $clog2(BUF_DEPTH);

    // Scoreboard: one {valid, rd} slot per multiplier stage.
    logic [MUL_STAGES-1:0] sb_valid;
    logic [RW-1:0]         sb_rd [MUL_STAGES];
    logic                  sb_load;

    // Holdover FIFO. Per-slot valid bits make the pending lookup position-free.
    logic [RW-1:0]         fifo_rd   [BUF_DEPTH];
    logic [REG_WIDTH-1:0]  fifo_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  fifo_vld;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic [NUM_REGS-1:0]   pend_vec;
    logic                  hazard;
    logic                  fire;

    logic                  fifo_full;
    logic                  wr_sel;
    logic [RW-1:0]         wr_addr;
    logic [REG_WIDTH-1:0]  wr_data;
    logic                  pop;
    logic                  push;
    logic                  direct;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        pend_vec = '0;
        for (int i = 0; i < MUL_STAGES; i++) begin
            if (sb_valid[i]) pend_vec[sb_rd[i]] = 1'b1;
        end
        for (int j = 0; j < BUF_DEPTH; j++) begin
            if (fifo_vld[j]) pend_vec[fifo_rd[j]] = 1'b1;
        end
        // r0 is hardwired, so it never creates a dependency.
        pend_vec[0] = 1'b0;
    end

    always_comb begin
        hazard = (issue_ra_use && pend_vec[issue_ra]) ||
                 (issue_rb_use && pend_vec[issue_rb]) ||
                 (issue_wr     && pend_vec[issue_rd]);
    end

    assign issue_stall = !reset && issue_valid && hazard;
    assign fire        = issue_valid && !issue_stall;
    assign sb_load     = fire && issue_is_mul && issue_wr;

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_valid <= '0;
            for (int i = 0; i < MUL_STAGES; i++) sb_rd[i] <= '0;
        end else begin
            sb_valid <= {sb_valid[MUL_STAGES-2:0], sb_load};
            sb_rd[0] <= issue_rd;
            for (int i = 1; i < MUL_STAGES; i++) sb_rd[i] <= sb_rd[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Write-port arbitration
    // ------------------------------------------------------------------
    assign fifo_full = (count == CW'(BUF_DEPTH));

    always_comb begin
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        pop     = 1'b0;
        direct  = 1'b0;
        if (fifo_full) begin
            // A full FIFO must drain first, otherwise a completing multiply
            // would have nowhere to go.
            wr_sel  = 1'b1;
            wr_addr = fifo_rd[head];
            wr_data = fifo_data[head];
            pop     = 1'b1;
        end else if (wb_valid) begin
            wr_sel  = 1'b1;
            wr_addr = wb_rd;
            wr_data = wb_data;
        end else if (count != '0) begin
            wr_sel  = 1'b1;
            wr_addr = fifo_rd[head];
            wr_data = fifo_data[head];
            pop     = 1'b1;
        end else if (mul_done_valid) begin
            wr_sel  = 1'b1;
            wr_addr = mul_done_rd;
            wr_data = mul_done_data;
            direct  = 1'b1;
        end
        push = mul_done_valid && !direct;
    end

    // Outputs are forced to their idle values during the reset cycle itself.
    always_comb begin
        if (reset) begin
            wb_ready  = 1'b1;
            rf_we     = 1'b0;
            rf_waddr  = '0;
            rf_wdata  = '0;
            buf_count = '0;
        end else begin
            wb_ready  = !fifo_full;
            // Writes to r0 still consume the slot and retire the entry.
            rf_we     = wr_sel && (wr_addr != '0);
            rf_waddr  = wr_addr;
            rf_wdata  = wr_data;
            buf_count = count;
        end
    end

    // ------------------------------------------------------------------
    // Holdover FIFO state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            // Pop is written before push: when full, head == tail, and the
            // push must win on the shared valid bit.
            if (pop) begin
                fifo_vld[head] <= 1'b0;
                head           <= head + PW'(1);
            end
            if (push) begin
                fifo_vld[tail]  <= 1'b1;
                fifo_rd[tail]   <= mul_done_rd;
                fifo_data[tail] <= mul_done_data;
                tail            <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
